dec_4x16_w_fault_3: RTL and testbench

- 4-to-16 line decoder built structurally from two 3-to-8 sub-decoders.
- X selects the sub-decoder: X=0 enables the lower one (D[7:0]), X=1 enables the upper one (D[15:8]). Y, Z, W drive both sub-decoders' select inputs.
- Used as a fault-injection test article: a build-time option forces fault #3, a stuck-at-0 on line 3 of the lower sub-decoder.
- Output is registered, and a self-check flag reports whether the output is a valid one-hot code.

---
 rtl/dec_4x16_w_fault_3.sv | 74 +++++++
 tb/tb_dec_4x16_w_fault_3.sv | 100 ++++++++++
 2 files changed

// File: rtl/dec_4x16_w_fault_3.sv
// Registered 4-to-16 decoder built from two 3-to-8 sub-decoders, with one-hot self-check.
// Define DEC_FAULT3_EN to inject a stuck-at-0 on lower sub-decoder line 3.
module dec_3x8 (
   input  logic       i_en,
   input  logic [2:0] i_sel,
   output logic [7:0] o_y
);
   always_comb begin
      o_y = 8'h00;
      for (int k = 0; k < 8; k++) begin
         o_y[k] = i_en & (i_sel == 3'(k));
      end
   end
endmodule

module dec_4x16_w_fault_3 (
   input  logic        clk,
   input  logic        rst,
   input  logic        X,
   input  logic        Y,
   input  logic        Z,
   input  logic        W,
   input  logic        en,
   output logic [15:0] D,
   output logic        onehot_ok
);
   logic [2:0]  w_sel_lo;
   logic [7:0]  w_lo;
   logic [7:0]  w_lo_f;
   logic [7:0]  w_hi;
   logic [15:0] w_d_next;
   logic        w_onehot;
   logic [15:0] r_d;
   logic        r_ok;

   assign w_sel_lo = {Y, Z, W};

   dec_3x8 u_lo (
      .i_en  (en & ~X),
      .i_sel (w_sel_lo),
      .o_y   (w_lo)
   );

   dec_3x8 u_hi (
      .i_en  (en & X),
      .i_sel (w_sel_lo),
      .o_y   (w_hi)
   );

`ifdef DEC_FAULT3_EN
   assign w_lo_f = w_lo & 8'hF7;
`else
   assign w_lo_f = w_lo;
`endif

   assign w_d_next = {w_hi, w_lo_f};

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign w_onehot = (w_d_next != 16'h0000) &&
                     ((w_d_next & (w_d_next - 16'h0001)) == 16'h0000);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d  <= 16'h0000;
         r_ok <= 1'b0;
      end else begin
         r_d  <= w_d_next;
         r_ok <= w_onehot;
      end
   end

   assign D         = r_d;
   assign onehot_ok = r_ok;
endmodule

// File: tb/tb_dec_4x16_w_fault_3.sv
// Self-checking bench for dec_4x16_w_fault_3: directed plan plus random traffic.
// Reference model follows the DEC_FAULT3_EN build option.
module tb_dec_4x16_w_fault_3;
   logic        clk = 1'b0;
   logic        rst;
   logic        X, Y, Z, W;
   logic        en;
   logic [15:0] D;
   logic        onehot_ok;

   int checks   = 0;
   int failures = 0;

   dec_4x16_w_fault_3 dut (
      .clk       (clk),
      .rst       (rst),
      .X         (X),
      .Y         (Y),
      .Z         (Z),
      .W         (W),
      .en        (en),
      .D         (D),
      .onehot_ok (onehot_ok)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_d(input logic e, input int s);
      logic [15:0] v;
      if (!e) return 16'h0000;
      v = 16'h0001 << s;
`ifdef DEC_FAULT3_EN
      if (s == 3) v = 16'h0000;
`endif
      return v;
   endfunction

   task automatic step(input logic r, input logic e, input int s, input string tag);
      logic [15:0] ed;
      logic        eo;
      logic [3:0]  sv;
      sv = 4'(s);
      @(negedge clk);
      rst = r;
      en  = e;
      {X, Y, Z, W} = sv;
      @(posedge clk);
      #1;
      if (r) begin
         ed = 16'h0000;
         eo = 1'b0;
      end else begin
         ed = model_d(e, s);
         eo = ($countones(ed) == 1);
      end
      checks++;
      assert (D === ed) else begin
         failures++;
         $error("FAIL %s D=%h expected=%h", tag, D, ed);
      end
      checks++;
      assert (onehot_ok === eo) else begin
         failures++;
         $error("FAIL %s_ok onehot_ok=%b expected=%b", tag, onehot_ok, eo);
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      {X, Y, Z, W} = 4'hF;

      step(1'b1, 1'b1, 15, "reset0");
      step(1'b1, 1'b1, 15, "reset1");
      step(1'b0, 1'b1, 15, "post_reset");

      for (int s = 0; s < 9; s++) step(1'b0, 1'b1, s, "sweep");
      step(1'b1, 1'b1, 9, "mid_reset");
      for (int s = 9; s < 16; s++) step(1'b0, 1'b1, s, "sweep");

      step(1'b0, 1'b1, 7, "split7");
      step(1'b0, 1'b1, 8, "split8");

      step(1'b0, 1'b0, 5, "en_off");
      step(1'b0, 1'b1, 5, "en_on");

      step(1'b0, 1'b1, 3, "code3");
      step(1'b0, 1'b1, 2, "code2");
      step(1'b0, 1'b1, 11, "code11");
      step(1'b0, 1'b0, 3, "code3_off");

      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 15)), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
